// File: rtl/cf_math_pkg.sv
// -----------------------------------------------------------------------------
// cf_math_pkg
// Purpose : shared arithmetic helpers for parameter derivation.
// Contents: idx_width(n) - number of bits needed to address n items
//           (minimum 1, so a single-item index still gets one bit).
// -----------------------------------------------------------------------------
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    if (num_idx > 32'd1) begin
      return unsigned'($clog2(num_idx));
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/mask_assembler_pkg.sv
// -----------------------------------------------------------------------------
// mask_assembler_pkg
// Purpose : shared types for the mask assembler.
// Contents: state_e - FILL (collecting indices) / DRAIN (mask offered on output)
// -----------------------------------------------------------------------------
package mask_assembler_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/mask_assembler_bin2onehot_dec.sv
// -----------------------------------------------------------------------------
// bin2onehot_dec
// Purpose : binary index to one-hot decoder. Indices >= WIDTH decode to all
//           zeros, which the caller uses as the out-of-range indication.
// Ports   : idx_i    [IDX_WIDTH] binary index
//           onehot_o [WIDTH]     one-hot vector (all-zero when idx_i >= WIDTH)
// -----------------------------------------------------------------------------
module bin2onehot_dec #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDX_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic [WIDTH-1:0]     onehot_o
);

  // Compare against every legal position; unmatched indices leave all bits low.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (idx_i == IDX_WIDTH'(i)) begin
        onehot_o[i] = 1'b1;
      end else begin
        onehot_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mask_assembler.sv
// -----------------------------------------------------------------------------
// mask_assembler
// Purpose : collects bit indices over a ready/valid stream into a WIDTH-bit
//           mask and emits it (with its popcount) when the mask is full or on
//           flush. Out-of-range indices are consumed and flagged on err_o.
// Build option: MASK_ASSEMBLER_DUP_CHECK_EN - when defined, an index whose bit
//           is already set is also flagged on err_o (it never changes the mask
//           or count in either build).
// Ports   : clk_i, rst_ni           clock, async active-low reset
//           flush_i                 emit the partial mask (ignored if empty)
//           idx_i, idx_valid_i,
//           idx_ready_o             index input handshake
//           mask_o, cnt_o,
//           mask_valid_o,
//           mask_ready_i            mask output handshake
//           err_o                   one-cycle pulse on a rejected index
// -----------------------------------------------------------------------------
module mask_assembler
  import mask_assembler_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDX_WIDTH = cf_math_pkg::idx_width(WIDTH),
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic                 idx_valid_i,
  output logic                 idx_ready_o,
  output logic [WIDTH-1:0]     mask_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 mask_valid_o,
  input  logic                 mask_ready_i,
  output logic                 err_o
);

  state_e               state_q;
  logic [WIDTH-1:0]     mask_q;
  logic [WIDTH-1:0]     mask_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 err_q;
  logic                 err_d;
  logic                 idx_ready_q;
  logic                 mask_valid_q;

  logic [WIDTH-1:0]     onehot_s;
  logic                 accept_s;
  logic                 oor_s;
  logic                 new_bit_s;
  logic                 go_drain_s;

  bin2onehot_dec #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_dec (
    .idx_i    (idx_i),
    .onehot_o (onehot_s)
  );

  // Index classification and the FILL-state datapath update.
  always_comb begin
    accept_s  = idx_valid_i & idx_ready_q;
    // The decoder returns zero for idx_i >= WIDTH.
    oor_s     = accept_s & ~(|onehot_s);
    // Only a bit not yet set advances the count, so cnt stays equal to popcount.
    new_bit_s = accept_s & (|(onehot_s & ~mask_q));
    if (new_bit_s) begin
      mask_d = mask_q | onehot_s;
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end else begin
      mask_d = mask_q;
      cnt_d  = cnt_q;
    end
`ifdef MASK_ASSEMBLER_DUP_CHECK_EN
    err_d = oor_s | (accept_s & (|(onehot_s & mask_q)));
`else
    err_d = oor_s;
`endif
    // Full mask always drains; flush only drains a non-empty result.
    go_drain_s = (&mask_d) | (flush_i & (|mask_d));
  end

  // FSM with registered handshake flags, mask, count and error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FILL;
      mask_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      idx_ready_q  <= 1'b1;
      mask_valid_q <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        FILL: begin
          mask_q <= mask_d;
          cnt_q  <= cnt_d;
          if (go_drain_s) begin
            state_q      <= DRAIN;
            idx_ready_q  <= 1'b0;
            mask_valid_q <= 1'b1;
          end else begin
            state_q      <= FILL;
            idx_ready_q  <= 1'b1;
            mask_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (mask_ready_i) begin
            state_q      <= FILL;
            mask_q       <= '0;
            cnt_q        <= '0;
            idx_ready_q  <= 1'b1;
            mask_valid_q <= 1'b0;
          end else begin
            state_q      <= DRAIN;
            idx_ready_q  <= 1'b0;
            mask_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= FILL;
          mask_q       <= '0;
          cnt_q        <= '0;
          idx_ready_q  <= 1'b1;
          mask_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign idx_ready_o  = idx_ready_q;
  assign mask_valid_o = mask_valid_q;
  assign mask_o       = mask_q;
  assign cnt_o        = cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mask_assembler.sv
// -----------------------------------------------------------------------------
// tb_mask_assembler
// Directed bench: an 8-bit instance for the main scenarios and a 6-bit
// instance for out-of-range index handling.
// -----------------------------------------------------------------------------
module tb_mask_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // 8-bit instance
  logic       flush = 1'b0;
  logic [2:0] idx = 3'd0;
  logic       idx_valid = 1'b0;
  logic       idx_ready;
  logic [7:0] mask;
  logic [3:0] cnt;
  logic       mask_valid;
  logic       mask_ready = 1'b0;
  logic       err;

  // 6-bit instance
  logic       flush6 = 1'b0;
  logic [2:0] idx6 = 3'd0;
  logic       idx_valid6 = 1'b0;
  logic       idx_ready6;
  logic [5:0] mask6;
  logic [2:0] cnt6;
  logic       mask_valid6;
  logic       mask_ready6 = 1'b0;
  logic       err6;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_mask;
  logic       exp_dup_err;

  always #5 clk = ~clk;

  mask_assembler #(.WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .idx_i        (idx),
    .idx_valid_i  (idx_valid),
    .idx_ready_o  (idx_ready),
    .mask_o       (mask),
    .cnt_o        (cnt),
    .mask_valid_o (mask_valid),
    .mask_ready_i (mask_ready),
    .err_o        (err)
  );

  mask_assembler #(.WIDTH(6)) dut6 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush6),
    .idx_i        (idx6),
    .idx_valid_i  (idx_valid6),
    .idx_ready_o  (idx_ready6),
    .mask_o       (mask6),
    .cnt_o        (cnt6),
    .mask_valid_o (mask_valid6),
    .mask_ready_i (mask_ready6),
    .err_o        (err6)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MASK_ASSEMBLER_DUP_CHECK_EN
    exp_dup_err = 1'b1;
`else
    exp_dup_err = 1'b0;
`endif

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(idx_ready), 32'd1);
    check_eq("rst_valid", 32'(mask_valid), 32'd0);
    check_eq("rst_mask", 32'(mask), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill all eight bits
    exp_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx_valid = 1'b1;
      idx = 3'(i);
      step();
      exp_mask = exp_mask | (8'h01 << i);
      check_eq("fill_mask", 32'(mask), 32'(exp_mask));
      check_eq("fill_cnt", 32'(cnt), 32'(i + 1));
      check_eq("fill_valid", 32'(mask_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    check_eq("full_ready", 32'(idx_ready), 32'd0);
    idx_valid = 1'b0;
    mask_ready = 1'b1;
    step();
    check_eq("full_hs_valid", 32'(mask_valid), 32'd0);
    check_eq("full_hs_ready", 32'(idx_ready), 32'd1);
    check_eq("full_hs_mask", 32'(mask), 32'd0);
    check_eq("full_hs_cnt", 32'(cnt), 32'd0);
    mask_ready = 1'b0;

    // 3, then 5 with flush -> 8'h28
    idx_valid = 1'b1;
    idx = 3'd3;
    step();
    idx = 3'd5;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_mask", 32'(mask), 32'h28);
    check_eq("flush_cnt", 32'(cnt), 32'd2);
    check_eq("flush_valid", 32'(mask_valid), 32'd1);
    idx = 3'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("drain_ready", 32'(idx_ready), 32'd0);
      check_eq("drain_mask", 32'(mask), 32'h28);
    end
    mask_ready = 1'b1;
    step();
    idx_valid = 1'b0;
    mask_ready = 1'b0;
    check_eq("flush_hs_ready", 32'(idx_ready), 32'd1);
    check_eq("flush_hs_mask", 32'(mask), 32'd0);
    check_eq("flush_hs_valid", 32'(mask_valid), 32'd0);

    // Empty flush is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("empty_flush_valid", 32'(mask_valid), 32'd0);
    check_eq("empty_flush_ready", 32'(idx_ready), 32'd1);
    step();
    check_eq("empty_flush_valid2", 32'(mask_valid), 32'd0);

    // WIDTH=6: index 5 accepted, index 7 rejected
    idx_valid6 = 1'b1;
    idx6 = 3'd5;
    step();
    check_eq("w6_mask5", 32'(mask6), 32'h20);
    check_eq("w6_err0", 32'(err6), 32'd0);
    idx6 = 3'd7;
    step();
    idx_valid6 = 1'b0;
    check_eq("w6_oor_err", 32'(err6), 32'd1);
    check_eq("w6_oor_mask", 32'(mask6), 32'h20);
    check_eq("w6_oor_cnt", 32'(cnt6), 32'd1);
    step();
    check_eq("w6_err_pulse", 32'(err6), 32'd0);
    check_eq("w6_valid", 32'(mask_valid6), 32'd0);

    // Duplicate index 2
    idx_valid = 1'b1;
    idx = 3'd2;
    step();
    check_eq("dup_first_err", 32'(err), 32'd0);
    check_eq("dup_first_mask", 32'(mask), 32'h04);
    step();
    idx_valid = 1'b0;
    check_eq("dup_err", 32'(err), 32'(exp_dup_err));
    check_eq("dup_mask", 32'(mask), 32'h04);
    check_eq("dup_cnt", 32'(cnt), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("dup_err_clear", 32'(err), 32'd0);
    check_eq("dup_flush_valid", 32'(mask_valid), 32'd1);
    check_eq("dup_flush_mask", 32'(mask), 32'h04);
    check_eq("dup_flush_cnt", 32'(cnt), 32'd1);
    mask_ready = 1'b1;
    step();
    mask_ready = 1'b0;
    check_eq("dup_hs_valid", 32'(mask_valid), 32'd0);

    // Build 8'h0F, flush, stall, then reset mid-DRAIN
    idx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idx = 3'(i);
      step();
    end
    idx_valid = 1'b0;
    check_eq("hold_pre_valid", 32'(mask_valid), 32'd0);
    flush = 1'b1;
    step();
    check_eq("hold_valid", 32'(mask_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_mask", 32'(mask), 32'h0F);
      check_eq("hold_cnt", 32'(cnt), 32'd4);
      check_eq("hold_valid_stable", 32'(mask_valid), 32'd1);
    end
    flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_mask", 32'(mask), 32'd0);
    check_eq("arst_cnt", 32'(cnt), 32'd0);
    check_eq("arst_valid", 32'(mask_valid), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_ready", 32'(idx_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_ready", 32'(idx_ready), 32'd1);
    check_eq("post_rst_valid", 32'(mask_valid), 32'd0);
    check_eq("post_rst_mask", 32'(mask), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mask_assembler.md
MASK_ASSEMBLER -- requirements
Module: mask_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, mask width in bits, WIDTH >= 2.
REQ-002 SHALL have parameter IDX_WIDTH, default cf_math_pkg::idx_width(WIDTH), dependent, index width; not to be overridden.
REQ-003 SHALL have parameter CNT_WIDTH, default cf_math_pkg::idx_width(WIDTH+1), dependent, accepted-index count width.
REQ-004 SHALL have port clk_i, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, force emission of the partially built mask.
REQ-007 SHALL have port idx_i, input, IDX_WIDTH, bit index to set.
REQ-008 SHALL have port idx_valid_i / idx_ready_o, input / output, 1 each, index handshake.
REQ-009 SHALL have port mask_o, output, WIDTH, assembled mask.
REQ-010 SHALL have port cnt_o, output, CNT_WIDTH, number of distinct bits set in mask_o.
REQ-011 SHALL have port mask_valid_o / mask_ready_i, output / input, 1 each, mask handshake.
REQ-012 SHALL have port err_o, output, 1, one-cycle pulse on a rejected index.

Function
REQ-013 SHALL implement a two-state FSM: FILL and DRAIN.
REQ-014 In FILL, SHALL drive idx_ready_o=1 and mask_valid_o=0.
REQ-015 In DRAIN, SHALL drive idx_ready_o=0 and mask_valid_o=1, and SHALL hold mask_o and cnt_o stable.
REQ-016 On an accepted index (valid&ready, idx_i < WIDTH, bit clear), SHALL set mask bit idx_i and increment cnt in the next cycle.
REQ-017 An index with idx_i >= WIDTH SHALL be consumed with no mask change and SHALL pulse err_o the following cycle.
REQ-018 FILL->DRAIN SHALL occur at the clock edge where the updated mask becomes all-ones; mask_valid_o SHALL rise one cycle after that final accept.
REQ-019 flush_i in FILL SHALL cause FILL->DRAIN at that edge, including any index accepted in the same cycle, provided the resulting mask is non-zero.
REQ-020 flush_i with a resulting mask of zero SHALL be ignored, and the block SHALL stay in FILL.
REQ-021 flush_i in DRAIN SHALL be ignored.
REQ-022 DRAIN->FILL SHALL occur on mask_valid_o&mask_ready_i, clearing mask and cnt at that same edge; idx_ready_o SHALL be 1 in the next cycle.
REQ-023 mask_valid_o, once asserted, SHALL NOT deassert before the handshake.
REQ-024 cnt_o SHALL always equal popcount(mask_o) and SHALL never exceed WIDTH.

Reset
REQ-025 Asserting rst_ni low SHALL asynchronously force FILL, mask_o=0, cnt_o=0, err_o=0, mask_valid_o=0; idx_ready_o SHALL be 1 after reset.
REQ-026 Reset mid-DRAIN SHALL discard the pending mask without emission.

Configuration
REQ-027 With MASK_ASSEMBLER_DUP_CHECK_EN defined, an index whose bit is already set SHALL be consumed with no mask/cnt change and SHALL pulse err_o the next cycle.
REQ-028 Without MASK_ASSEMBLER_DUP_CHECK_EN, a duplicate index SHALL be silently consumed, with no mask change, no count change and err_o=0; the out-of-range check SHALL remain in both builds.

Structure
REQ-029 The FSM state enum (FILL, DRAIN) SHALL reside in the shared package mask_assembler_pkg.
REQ-030 IDX_WIDTH/CNT_WIDTH SHALL use cf_math_pkg::idx_width.
REQ-031 The index-to-one-hot conversion SHALL be a sub-module, bin2onehot_dec (parameter WIDTH; in idx, out one-hot, all-zero for out-of-range).

Verification
REQ-032 Scenario: WIDTH=8, send indices 0..7 with mask_ready_i=1 -> mask_o=8'hFF, cnt_o=8, mask_valid_o high exactly one cycle after the 8th accept, handshake the next cycle.
REQ-033 Scenario: send 3, then 5 with flush_i in the same cycle -> mask_o=8'h28, cnt_o=2; idx_valid_i held high during DRAIN sees idx_ready_o=0 until the handshake.
REQ-034 Scenario: flush_i with an empty mask and no index -> no mask_valid_o; WIDTH=6, idx_i=7 -> err_o single-cycle pulse, mask unchanged.
REQ-035 Scenario: send 2 twice, then flush -> mask_o=8'h04, cnt_o=1; err_o pulses once with the macro defined and stays 0 without it.
REQ-036 Scenario: build 8'h0F and flush, hold mask_ready_i=0 for 5 cycles -> mask_o stable; assert rst_ni low mid-DRAIN -> all outputs zero, FILL state, idx_ready_o=1.
